miner_core_ccu: RTL and testbench

Control sequencer for one SHA-256 double-hash miner core, with an integrated round timer. A single-cycle start request runs three hash passes. Each pass is message-schedule expansion (48 cycles), compression (64 cycles) and a one-cycle add. The block drives the stage enables and the round index for the datapath (message-schedule array, compressor, adders), then pulses finished.

---
 rtl/miner_core_ccu.sv | 145 ++++++++++++++
 tb/tb_miner_core_ccu.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/miner_core_ccu.sv
// miner_core_ccu: control sequencer for one SHA-256 double-hash miner core.
// A start request runs three passes of message-schedule expansion, compression
// and hash add. Each pass drives the stage enables and the round index for the
// datapath. The sequence ends with a one-cycle finished pulse.
// Optional build macro MINER_CCU_BUSY_EN adds a busy output. busy is high in
// every state except IDLE.
module miner_core_ccu #(
  parameter int MSA_CYCLES  = 48,
  parameter int COMP_CYCLES = 64,
  parameter int IDX_W       = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hash_enable,
  output logic             msa_en,
  output logic             comp_en,
  output logic             add_en,
  output logic             msa2_en,
  output logic             comp2_en,
  output logic             add2_en,
  output logic [IDX_W-1:0] round_idx,
`ifdef MINER_CCU_BUSY_EN
  output logic             busy,
`endif
  output logic             finished
);

  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] MSA_LAST  = CNT_W'(MSA_CYCLES - 1);
  localparam logic [CNT_W-1:0] COMP_LAST = CNT_W'(COMP_CYCLES - 1);
  localparam logic [IDX_W-1:0] MSA_BASE  = IDX_W'(16);

  typedef enum logic [3:0] {
    S_IDLE,
    S_MSA1,
    S_COMP1,
    S_ADD1,
    S_MSA2,
    S_COMP2,
    S_ADD2,
    S_MSA3,
    S_COMP3,
    S_ADD3,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic             in_msa;
  logic             in_comp;
  logic             msa_last;
  logic             comp_last;

  assign in_msa    = (state == S_MSA1) || (state == S_MSA2) || (state == S_MSA3);
  assign in_comp   = (state == S_COMP1) || (state == S_COMP2) || (state == S_COMP3);
  assign msa_last  = in_msa && (count == MSA_LAST);
  assign comp_last = in_comp && (count == COMP_LAST);

  // State register. Async reset parks the sequencer in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Round timer. It is cleared on every state change and runs only in the
  // timed stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (state_nxt != state) begin
      count <= '0;
    end else if (in_msa || in_comp) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

  // Next-state sequencing. hash_enable only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hash_enable) state_nxt = S_MSA1;
      S_MSA1:  if (msa_last)    state_nxt = S_COMP1;
      S_COMP1: if (comp_last)   state_nxt = S_ADD1;
      S_ADD1:                   state_nxt = S_MSA2;
      S_MSA2:  if (msa_last)    state_nxt = S_COMP2;
      S_COMP2: if (comp_last)   state_nxt = S_ADD2;
      S_ADD2:                   state_nxt = S_MSA3;
      S_MSA3:  if (msa_last)    state_nxt = S_COMP3;
      S_COMP3: if (comp_last)   state_nxt = S_ADD3;
      S_ADD3:                   state_nxt = S_DONE;
      S_DONE:                   state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode from the state and the timer count.
  // Passes 1 and 3 share the msa/comp enables. The final add fires both adders.
  always_comb begin
    msa_en    = 1'b0;
    comp_en   = 1'b0;
    add_en    = 1'b0;
    msa2_en   = 1'b0;
    comp2_en  = 1'b0;
    add2_en   = 1'b0;
    finished  = 1'b0;
    round_idx = '0;
    case (state)
      S_MSA1, S_MSA3: begin
        msa_en    = 1'b1;
        round_idx = MSA_BASE + IDX_W'(count);
      end
      S_COMP1, S_COMP3: begin
        comp_en   = 1'b1;
        round_idx = IDX_W'(count);
      end
      S_ADD1: add_en = 1'b1;
      S_MSA2: begin
        msa2_en   = 1'b1;
        round_idx = MSA_BASE + IDX_W'(count);
      end
      S_COMP2: begin
        comp2_en  = 1'b1;
        round_idx = IDX_W'(count);
      end
      S_ADD2: add2_en = 1'b1;
      S_ADD3: begin
        add_en  = 1'b1;
        add2_en = 1'b1;
      end
      S_DONE: finished = 1'b1;
      default: ;
    endcase
  end

`ifdef MINER_CCU_BUSY_EN
  assign busy = (state != S_IDLE);
`endif

endmodule

// File: tb/tb_miner_core_ccu.sv
// Scoreboard bench for miner_core_ccu.
// A cycle-offset reference model pushes the expected output vector on every
// rising edge. The checker pops that vector on the falling edge and compares it
// with the DUT outputs.
module tb_miner_core_ccu;

  localparam int IDX_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hash_enable = 1'b0;
  logic             msa_en, comp_en, add_en, msa2_en, comp2_en, add2_en;
  logic             finished;
  logic [IDX_W-1:0] round_idx;
  logic             busy_o;

  int               n_cmp = 0;
  int               n_err = 0;
  int               t_ref = 0;
  logic [14:0]      sb[$];

  miner_core_ccu #(.MSA_CYCLES(48), .COMP_CYCLES(64), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .hash_enable(hash_enable),
    .msa_en     (msa_en),
    .comp_en    (comp_en),
    .add_en     (add_en),
    .msa2_en    (msa2_en),
    .comp2_en   (comp2_en),
    .add2_en    (add2_en),
    .round_idx  (round_idx),
`ifdef MINER_CCU_BUSY_EN
    .busy       (busy_o),
`endif
    .finished   (finished)
  );

`ifndef MINER_CCU_BUSY_EN
  assign busy_o = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected output vector at run offset k.
  // Offset 0 is IDLE. Offset 1 is the first MSA1 cycle. Offset 340 is DONE.
  // The vector layout is {busy, msa, comp, add, msa2, comp2, add2, finished, idx}.
  function automatic logic [14:0] exp_vec(input int k);
    logic m, c, a, m2, c2, a2, f, b;
    int   idx;
    m = 0; c = 0; a = 0; m2 = 0; c2 = 0; a2 = 0; f = 0; idx = 0;
    if (k >= 1 && k <= 48)         begin m  = 1; idx = 16 + k - 1;   end
    else if (k >= 49 && k <= 112)  begin c  = 1; idx = k - 49;       end
    else if (k == 113)             begin a  = 1;                     end
    else if (k >= 114 && k <= 161) begin m2 = 1; idx = 16 + k - 114; end
    else if (k >= 162 && k <= 225) begin c2 = 1; idx = k - 162;      end
    else if (k == 226)             begin a2 = 1;                     end
    else if (k >= 227 && k <= 274) begin m  = 1; idx = 16 + k - 227; end
    else if (k >= 275 && k <= 338) begin c  = 1; idx = k - 275;      end
    else if (k == 339)             begin a  = 1; a2 = 1;             end
    else if (k == 340)             begin f  = 1;                     end
`ifdef MINER_CCU_BUSY_EN
    b = (k != 0);
`else
    b = 1'b0;
`endif
    return {b, m, c, a, m2, c2, a2, f, 7'(idx)};
  endfunction

  // Reference model: advance the run offset on each rising edge and queue the
  // expected outputs.
  always @(posedge clk) begin
    int nt;
    if (rst)                       nt = 0;
    else if (t_ref == 0)           nt = hash_enable ? 1 : 0;
    else if (t_ref == 340)         nt = 0;
    else                           nt = t_ref + 1;
    t_ref <= nt;
    sb.push_back(exp_vec(nt));
  end

  // Checker: compare the DUT outputs with the scoreboard on the falling edge.
  // It also checks that the stage enables are mutually exclusive.
  always @(negedge clk) begin
    logic [14:0] exp_v;
    logic [14:0] obs_v;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      obs_v = {busy_o, msa_en, comp_en, add_en, msa2_en, comp2_en, add2_en,
               finished, round_idx};
      chk("outputs", 32'(obs_v), 32'(exp_v));
      chk("stage_mutex", 32'(($countones({msa_en, comp_en, msa2_en, comp2_en}) <= 1) ? 1 : 0), 32'd1);
      chk("finished_excl", 32'(finished & (msa_en | comp_en | add_en | msa2_en | comp2_en | add2_en)), 32'd0);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({busy_o, msa_en, comp_en, add_en, msa2_en, comp2_en, add2_en, finished, round_idx}), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    // Reset at power-up, released away from the clock edge.
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    chk_all_zero("idle_after_reset");

    // Mid-cycle reset with hash_enable low. The block keeps idling.
    #2 rst = 1'b1;
    #1 chk_all_zero("reset_mid_cycle");
    step();
    rst = 1'b0;
    repeat (4) step();

    // Single-cycle start pulse, followed by a complete run.
    hash_enable = 1'b1;
    step();
    hash_enable = 1'b0;
    chk("first_idx", 32'(round_idx), 32'd16);
    chk("first_msa", 32'(msa_en), 32'd1);
    repeat (350) step();

    // hash_enable held high. There is no retrigger mid-run. A new run starts
    // after one IDLE cycle.
    hash_enable = 1'b1;
    repeat (720) step();
    hash_enable = 1'b0;
    repeat (360) step();

    // Reset during COMP2 at round 20, then restart from a fresh pulse.
    hash_enable = 1'b1;
    step();
    hash_enable = 1'b0;
    waited = 0;
    while (!(comp2_en && round_idx == 7'd20) && waited < 400) begin
      step();
      waited++;
    end
    chk("reach_comp2_r20", 32'(waited < 400), 32'd1);
    rst = 1'b1;
    #1 chk_all_zero("reset_in_comp2");
    step();
    chk_all_zero("reset_held");
    rst = 1'b0;
    repeat (3) step();
    chk_all_zero("idle_after_comp2_reset");
    hash_enable = 1'b1;
    step();
    hash_enable = 1'b0;
    chk("restart_idx", 32'(round_idx), 32'd16);
    chk("restart_msa", 32'(msa_en), 32'd1);
    repeat (350) step();
    chk("scoreboard_drained", 32'(sb.size() <= 1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
